imem_port_arbiter: RTL and testbench
====================================

Name: imem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between two requesters: the fetch stage (PC, instrmem_rd) and the load path (l_macc, data_rd).
- Sequences each access through a fixed-latency memory read, returns read data with a one-cycle completion pulse, and arbitrates with data priority plus a starvation guard for fetch.
- Sits between the LC3 fetch/memory-access logic and the memory model driven by the imem agent.

Parameters:
- ADDR_W, 16, address width for PC, l_macc and mem_addr.
- DATA_W, 16, data width for mem_rdata, instr_dout and data_dout.
- MEM_LATENCY, 2, cycles from mem_rd assertion to valid mem_rdata; legal range 1..15.
- MAX_DATA_STREAK, 3, consecutive data grants allowed while a fetch waits; legal range 1..15.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- PC  input  ADDR_W  fetch address; sampled at grant.
- instrmem_rd  input  1  fetch request; level, held until complete_instr.
- instr_dout  output  DATA_W  fetched instruction; valid from complete_instr, held until next fetch completion.
- complete_instr  output  1  one-cycle fetch completion pulse.
- l_macc  input  ADDR_W  load address; sampled at grant.
- data_rd  input  1  load request; level, held until complete_data.
- data_dout  output  DATA_W  load data; held until next load completion.
- complete_data  output  1  one-cycle load completion pulse.
- mem_addr  output  ADDR_W  memory address, registered.
- mem_rd  output  1  memory read strobe, one-cycle pulse.
- mem_rdata  input  DATA_W  memory read data; valid MEM_LATENCY cycles after mem_rd.
- busy  output  1  high whenever state is not IDLE.
- grant_src  output  1  owner of the current transaction: 0 = fetch, 1 = data.

Behaviour:
- Reset:
  - state = IDLE.
  - All outputs = 0: instr_dout, data_dout, mem_addr, mem_rd, complete_*, busy, grant_src.
  - Latency counter and streak counter = 0.
  - Reset asserted mid-transaction drops the access; no completion pulse is issued.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If either request is high at edge T, go to ISSUE.
  - Latch the winning address into mem_addr and the winner into grant_src.
- ISSUE (cycle T+1):
  - mem_rd = 1 for exactly this cycle.
  - Counter loads MEM_LATENCY-1; go to WAIT.
  - When MEM_LATENCY = 1, go straight to capture: mem_rdata is valid in cycle T+1+1.
- WAIT:
  - Decrement the counter each cycle.
  - In cycle T+1+MEM_LATENCY, capture mem_rdata into instr_dout or data_dout (selected by grant_src), then go to DONE.
- DONE (cycle T+2+MEM_LATENCY):
  - The matching complete_* = 1 and the updated dout is visible.
  - Return to IDLE; requests are not sampled in DONE.
  - Minimum request-to-complete latency = MEM_LATENCY+2; back-to-back grant spacing = MEM_LATENCY+3 cycles.
- Arbitration (IDLE only):
  - Only one requester high: it wins.
  - Both high: data wins, unless streak == MAX_DATA_STREAK, in which case fetch wins.
- Streak counter:
  - +1 on each data grant made while instrmem_rd is high, saturating at MAX_DATA_STREAK.
  - Cleared on any fetch grant.
  - Cleared on a data grant made while instrmem_rd is low.
- A request dropped after grant: the transaction still completes and pulses complete_*; the requester ignores it.
- Address and select changes after grant have no effect; mem_addr and grant_src hold until the next grant.
- mem_addr and grant_src retain their last value in IDLE.
- Only one complete_* is high in any cycle; never both.
- mem_rdata is ignored outside the capture cycle.

Test Plan:
- Single fetch, MEM_LATENCY=2: PC=16'h3000, instrmem_rd high at edge 0, mem returns 16'h1234 -> mem_rd high cycle 1 with mem_addr=16'h3000; complete_instr pulses cycle 4; instr_dout=16'h1234 and held afterwards.
- Simultaneous requests: PC=16'h3001, l_macc=16'h4000, both high at edge 0 -> data granted first (mem_addr=16'h4000, complete_data at cycle 4); fetch granted at edge 5 (mem_addr=16'h3001, complete_instr at cycle 9).
- Starvation, MAX_DATA_STREAK=3: data_rd and instrmem_rd held high continuously -> grant order data, data, data, fetch, data...; streak reads 0 after the fetch grant.
- Reset mid-WAIT: fetch granted, reset high in cycle 2 -> cycle 3 shows busy=0, mem_rd=0, instr_dout=0; no complete_instr ever pulses.
- MEM_LATENCY=1 build: data_rd with l_macc=16'h00FF, mem_rdata=16'hBEEF -> mem_rd cycle 1; complete_data cycle 3; data_dout=16'hBEEF.
- Request dropped after grant: instrmem_rd deasserted in cycle 2 -> complete_instr still pulses in cycle 4; FSM returns to IDLE with no further grant.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// Arbiter that shares one single-port memory between instruction fetch and the load path.
// Each access is an issue/wait/capture/done sequence; data has priority, with a streak limit that keeps fetch from starving.
module imem_port_arbiter #(
    parameter int unsigned ADDR_W          = 16,
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned MEM_LATENCY     = 2,
    parameter int unsigned MAX_DATA_STREAK = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] PC,
    input  logic              instrmem_rd,
    output logic [DATA_W-1:0] instr_dout,
    output logic              complete_instr,
    input  logic [ADDR_W-1:0] l_macc,
    input  logic              data_rd,
    output logic [DATA_W-1:0] data_dout,
    output logic              complete_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_src
);

    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_DATA_STREAK);

    logic [1:0]        state_q,          state_d;
    logic [CNT_W-1:0]  cnt_q,            cnt_d;
    logic [CNT_W-1:0]  streak_q,         streak_d;
    logic [ADDR_W-1:0] mem_addr_q,       mem_addr_d;
    logic              grant_src_q,      grant_src_d;
    logic              mem_rd_q,         mem_rd_d;
    logic [DATA_W-1:0] instr_dout_q,     instr_dout_d;
    logic [DATA_W-1:0] data_dout_q,      data_dout_d;
    logic              complete_instr_q, complete_instr_d;
    logic              complete_data_q,  complete_data_d;
    logic              busy_q,           busy_d;
    logic              pick_data_c;

    // Next-state and registered-output logic.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        streak_d         = streak_q;
        mem_addr_d       = mem_addr_q;
        grant_src_d      = grant_src_q;
        mem_rd_d         = 1'b0;
        instr_dout_d     = instr_dout_q;
        data_dout_d      = data_dout_q;
        complete_instr_d = 1'b0;
        complete_data_d  = 1'b0;
        pick_data_c      = data_rd && !(instrmem_rd && (streak_q == STREAK_MAX));

        case (state_q)
            S_IDLE: begin
                if (instrmem_rd || data_rd) begin
                    state_d     = S_ISSUE;
                    mem_rd_d    = 1'b1;
                    grant_src_d = pick_data_c;
                    mem_addr_d  = pick_data_c ? l_macc : PC;
                    // Streak only grows while a fetch is actually being held off.
                    if (pick_data_c && instrmem_rd) begin
                        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
                    end else begin
                        streak_d = '0;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = LAT_LOAD;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    if (grant_src_q) begin
                        data_dout_d     = mem_rdata;
                        complete_data_d = 1'b1;
                    end else begin
                        instr_dout_d     = mem_rdata;
                        complete_instr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            streak_q         <= '0;
            mem_addr_q       <= '0;
            grant_src_q      <= 1'b0;
            mem_rd_q         <= 1'b0;
            instr_dout_q     <= '0;
            data_dout_q      <= '0;
            complete_instr_q <= 1'b0;
            complete_data_q  <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            streak_q         <= streak_d;
            mem_addr_q       <= mem_addr_d;
            grant_src_q      <= grant_src_d;
            mem_rd_q         <= mem_rd_d;
            instr_dout_q     <= instr_dout_d;
            data_dout_q      <= data_dout_d;
            complete_instr_q <= complete_instr_d;
            complete_data_q  <= complete_data_d;
            busy_q           <= busy_d;
        end
    end

    assign mem_addr       = mem_addr_q;
    assign grant_src      = grant_src_q;
    assign mem_rd         = mem_rd_q;
    assign instr_dout     = instr_dout_q;
    assign data_dout      = data_dout_q;
    assign complete_instr = complete_instr_q;
    assign complete_data  = complete_data_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: a transaction-timing model checked every cycle on a MEM_LATENCY=2 instance,
// plus directed literal checks on that instance and on a MEM_LATENCY=1 instance.
module tb_imem_port_arbiter;

    localparam int LAT    = 2;
    localparam int STREAK = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [15:0] pc0, lm0, rdata0, idout0, ddout0, maddr0;
    logic        irq0, drd0, ci0, cd0, mrd0, busy0, gs0;
    logic [15:0] pc1, lm1, rdata1, idout1, ddout1, maddr1;
    logic        irq1, drd1, ci1, cd1, mrd1, busy1, gs1;

    imem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(2), .MAX_DATA_STREAK(3)) dut0 (
        .clock(clk), .reset(reset), .PC(pc0), .instrmem_rd(irq0), .instr_dout(idout0),
        .complete_instr(ci0), .l_macc(lm0), .data_rd(drd0), .data_dout(ddout0),
        .complete_data(cd0), .mem_addr(maddr0), .mem_rd(mrd0), .mem_rdata(rdata0),
        .busy(busy0), .grant_src(gs0)
    );

    imem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(1), .MAX_DATA_STREAK(3)) dut1 (
        .clock(clk), .reset(reset), .PC(pc1), .instrmem_rd(irq1), .instr_dout(idout1),
        .complete_instr(ci1), .l_macc(lm1), .data_rd(drd1), .data_dout(ddout1),
        .complete_data(cd1), .mem_addr(maddr1), .mem_rd(mrd1), .mem_rdata(rdata1),
        .busy(busy1), .grant_src(gs1)
    );

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        case (a)
            16'h3000: mem_fn = 16'h1234;
            16'h3001: mem_fn = 16'h5678;
            16'h4000: mem_fn = 16'hCAFE;
            16'h00FF: mem_fn = 16'hBEEF;
            default:  mem_fn = a ^ 16'h5A5A;
        endcase
    endfunction

    // Memory agents: data is only valid exactly MEM_LATENCY cycles after mem_rd, junk otherwise.
    logic        p0_v = 1'b0, p1_v = 1'b0, q_v = 1'b0;
    logic [15:0] p0_a = '0, p1_a = '0, q_a = '0;
    always @(posedge clk) begin
        p0_v <= mrd0;  p0_a <= maddr0;
        p1_v <= p0_v;  p1_a <= p0_a;
        q_v  <= mrd1;  q_a  <= maddr1;
    end
    assign rdata0 = p1_v ? mem_fn(p1_a) : 16'hDEAD;
    assign rdata1 = q_v  ? mem_fn(q_a)  : 16'hDEAD;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_t counts cycles since the grant edge (-1 = idle); ISSUE is t=0, DONE is t=LAT+1.
    int          m_t = -1;
    int          m_streak = 0;
    logic        m_src = 1'b0;
    logic [15:0] m_addr = '0, m_instr = '0, m_data = '0;
    bit          m_init = 1'b0;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_t = -1; m_streak = 0; m_src = 1'b0;
            m_addr = '0; m_instr = '0; m_data = '0; m_init = 1'b1;
        end else if (m_init) begin
            if (m_t < 0) begin
                if (irq0 || drd0) begin
                    m_src  = drd0 && !(irq0 && m_streak >= STREAK);
                    m_addr = m_src ? lm0 : pc0;
                    if (m_src && irq0) m_streak = (m_streak < STREAK) ? m_streak + 1 : STREAK;
                    else               m_streak = 0;
                    m_t = 0;
                end
            end else if (m_t == LAT + 1) begin
                m_t = -1;
            end else begin
                m_t = m_t + 1;
                if (m_t == LAT + 1) begin
                    if (m_src) m_data  = mem_fn(m_addr);
                    else       m_instr = mem_fn(m_addr);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("busy",           busy0,  m_t >= 0);
            chk("mem_rd",         mrd0,   m_t == 0);
            chk("mem_addr",       maddr0, m_addr);
            chk("grant_src",      gs0,    m_src);
            chk("complete_instr", ci0,    (m_t == LAT + 1) && !m_src);
            chk("complete_data",  cd0,    (m_t == LAT + 1) && m_src);
            chk("instr_dout",     idout0, m_instr);
            chk("data_dout",      ddout0, m_data);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int          pulses;
    int          ng;
    logic [4:0]  order;

    initial begin
        reset = 1'b1;
        pc0 = '0; lm0 = '0; irq0 = 1'b0; drd0 = 1'b0;
        pc1 = '0; lm1 = '0; irq1 = 1'b0; drd1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy0",  busy0,  0);
        chk("rst_mrd0",   mrd0,   0);
        chk("rst_maddr0", maddr0, 0);
        chk("rst_idout0", idout0, 0);
        chk("rst_busy1",  busy1,  0);
        chk("rst_idout1", idout1, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single fetch; PC changes after grant must not matter.
        pc0 = 16'h3000; irq0 = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin chk("s1_mrd", mrd0, 1); chk("s1_addr", maddr0, 16'h3000); end
            if (c == 2) pc0 = 16'hFFFF;
            if (c == 3) chk("s1_no_early_ci", ci0, 0);
            if (c == 4) begin chk("s1_ci", ci0, 1); chk("s1_dout", idout0, 16'h1234); irq0 = 1'b0; end
            if (c == 6) begin chk("s1_hold", idout0, 16'h1234); chk("s1_idle", busy0, 0); end
        end

        // Simultaneous requests: data first, fetch granted at edge 5.
        pc0 = 16'h3001; lm0 = 16'h4000; irq0 = 1'b1; drd0 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) begin chk("s2_addr_d", maddr0, 16'h4000); chk("s2_gs_d", gs0, 1); end
            if (c == 4) begin chk("s2_cd", cd0, 1); chk("s2_ddout", ddout0, 16'hCAFE); drd0 = 1'b0; end
            if (c == 6) begin chk("s2_mrd_f", mrd0, 1); chk("s2_addr_f", maddr0, 16'h3001); chk("s2_gs_f", gs0, 0); end
            if (c == 9) begin chk("s2_ci", ci0, 1); chk("s2_idout", idout0, 16'h5678); irq0 = 1'b0; end
        end

        // Starvation guard: both held high, expect data x3, fetch, data.
        pc0 = 16'h3003; lm0 = 16'h4002; irq0 = 1'b1; drd0 = 1'b1;
        ng = 0; order = '0;
        for (int c = 1; c <= 40 && ng < 5; c++) begin
            @(negedge clk);
            if (mrd0) begin order[ng] = gs0; ng++; end
        end
        irq0 = 1'b0; drd0 = 1'b0;
        chk("s3_grant_count", ng, 5);
        chk("s3_grant_order", order, 5'b10111);
        repeat (8) @(negedge clk);

        // Reset during WAIT drops the access silently.
        pc0 = 16'h3000; irq0 = 1'b1; pulses = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (ci0) pulses++;
            if (c == 2) begin reset = 1'b1; irq0 = 1'b0; end
            if (c == 3) begin
                chk("s4_busy", busy0, 0); chk("s4_mrd", mrd0, 0); chk("s4_idout", idout0, 0);
                reset = 1'b0;
            end
        end
        chk("s4_no_complete", pulses, 0);

        // Fetch dropped after grant still completes, then no further grant.
        pc0 = 16'h3002; irq0 = 1'b1; ng = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 2) irq0 = 1'b0;
            if (c == 4) begin chk("s5_ci", ci0, 1); chk("s5_idout", idout0, 16'h6A58); end
            if (c >= 5 && mrd0) ng++;
            if (c == 9) chk("s5_idle", busy0, 0);
        end
        chk("s5_no_regrant", ng, 0);

        // MEM_LATENCY=1 instance: single load.
        lm1 = 16'h00FF; drd1 = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) begin chk("s6_mrd", mrd1, 1); chk("s6_addr", maddr1, 16'h00FF); chk("s6_gs", gs1, 1); chk("s6_busy", busy1, 1); end
            if (c == 2) begin chk("s6_mrd_off", mrd1, 0); chk("s6_no_early_cd", cd1, 0); end
            if (c == 3) begin chk("s6_cd", cd1, 1); chk("s6_ci", ci1, 0); chk("s6_ddout", ddout1, 16'hBEEF); drd1 = 1'b0; end
            if (c == 4) begin chk("s6_cd_pulse", cd1, 0); chk("s6_hold", ddout1, 16'hBEEF); end
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
